temp_scan_ctrl: RTL and testbench

TEMP_SCAN_CTRL -- requirements
Module: temp_scan_ctrl

---
 rtl/temp_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_temp_scan_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/temp_scan_ctrl.sv
// Periodic five-sensor temperature scanner with rounded average and alert.
// Optional macro TEMP_ALERT_HYST_EN adds hysteresis to alert_o.
module temp_scan_ctrl #(
    parameter int SCAN_PERIOD = 1000,
    parameter int ALERT_LO    = 19,
    parameter int ALERT_HI    = 26
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [39:0] sensors_data_i,
    input  logic [4:0]  sensors_en_i,
    output logic [7:0]  led_output_o,
    output logic        alert_o,
    output logic        fault_o,
    output logic        busy_o,
    output logic        valid_o
);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam logic [7:0] LO8 = 8'(ALERT_LO);
    localparam logic [7:0] HI8 = 8'(ALERT_HI);

    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] per_cnt;
    logic          wrap_q;
    logic [39:0]   snap_data;
    logic [4:0]    snap_en;
    logic [15:0]   sum;
    logic [2:0]    cnt;
    logic [2:0]    idx;
    logic [3:0]    step;
    logic [15:0]   quo;
    logic [2:0]    rem;
    logic          fault_q;

    logic [7:0]  cur;
    logic        add_en;
    logic [15:0] sum_nx;
    logic [2:0]  cnt_nx;
    logic [3:0]  trial;
    logic        ge;
    logic        rnd;
    logic [16:0] avg_full;
    logic [7:0]  avg;
    logic        out_rng;

    assign cur      = snap_data[{idx, 3'b000} +: 8];
    assign add_en   = snap_en[idx];
    assign sum_nx   = sum + {8'd0, cur & {8{add_en}}};
    assign cnt_nx   = cnt + {2'b00, add_en};
    assign trial    = {rem, quo[15]};
    assign ge       = trial >= {1'b0, cnt};
    // Round half up: remainder at least half the divisor bumps the quotient.
    assign rnd      = {rem, 1'b0} >= {1'b0, cnt};
    assign avg_full = {1'b0, quo} + {16'd0, rnd};
    assign avg      = (avg_full > 17'd255) ? 8'hFF : avg_full[7:0];
    assign out_rng  = (avg < LO8) || (avg > HI8);
    assign busy_o   = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            per_cnt      <= '0;
            wrap_q       <= 1'b0;
            snap_data    <= '0;
            snap_en      <= '0;
            sum          <= '0;
            cnt          <= '0;
            idx          <= '0;
            step         <= '0;
            quo          <= '0;
            rem          <= '0;
            fault_q      <= 1'b0;
            led_output_o <= '0;
            alert_o      <= 1'b0;
            fault_o      <= 1'b0;
            valid_o      <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wrap_q || start_i) begin
                        snap_data <= sensors_data_i;
                        snap_en   <= sensors_en_i;
                        sum       <= '0;
                        cnt       <= '0;
                        idx       <= '0;
                        per_cnt   <= '0;
                        wrap_q    <= 1'b0;
                        state     <= ACCUM;
                    end else if (per_cnt == PW'(SCAN_PERIOD - 1)) begin
                        per_cnt <= '0;
                        wrap_q  <= 1'b1;
                    end else begin
                        per_cnt <= per_cnt + PW'(1);
                    end
                end
                ACCUM: begin
                    sum <= sum_nx;
                    cnt <= cnt_nx;
                    idx <= idx + 3'd1;
                    if (idx == 3'd4) begin
                        if (cnt_nx == 3'd0) begin
                            fault_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            fault_q <= 1'b0;
                            quo     <= sum_nx;
                            rem     <= '0;
                            step    <= '0;
                            state   <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    if (ge) begin
                        rem <= 3'(trial - {1'b0, cnt});
                    end else begin
                        rem <= trial[2:0];
                    end
                    quo  <= {quo[14:0], ge};
                    step <= step + 4'd1;
                    if (step == 4'd15) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    valid_o <= 1'b1;
                    state   <= IDLE;
                    if (fault_q) begin
                        led_output_o <= '0;
                        fault_o      <= 1'b1;
                        alert_o      <= 1'b1;
                    end else begin
                        led_output_o <= avg;
                        fault_o      <= 1'b0;
`ifdef TEMP_ALERT_HYST_EN
                        if (out_rng) begin
                            alert_o <= 1'b1;
                        end else if (avg > LO8 && avg < HI8) begin
                            alert_o <= 1'b0;
                        end
`else
                        alert_o <= out_rng;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Scoreboard bench for temp_scan_ctrl with a behavioural average model.
// Honours TEMP_ALERT_HYST_EN when the design is built with it.
module tb_temp_scan_ctrl;
    localparam int P  = 40;
    localparam int LO = 19;
    localparam int HI = 26;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [39:0] data = '0;
    logic [4:0]  en = '0;
    logic [7:0]  led_output_o;
    logic        alert_o;
    logic        fault_o;
    logic        busy_o;
    logic        valid_o;

    temp_scan_ctrl #(
        .SCAN_PERIOD(P),
        .ALERT_LO(LO),
        .ALERT_HI(HI)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .start_i(start),
        .sensors_data_i(data),
        .sensors_en_i(en),
        .led_output_o(led_output_o),
        .alert_o(alert_o),
        .fault_o(fault_o),
        .busy_o(busy_o),
        .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int led;
        int alert;
        int fault;
        int at;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   model_alert = 0;

    task automatic check(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Reference: integer mean rounded half up, alert from range rules.
    task automatic push_exp(input logic [39:0] d, input logic [4:0] e,
                            input int e0);
        exp_t x;
        int s = 0;
        int c = 0;
        int a;
        int out_r;
        for (int k = 0; k < 5; k++) begin
            if (e[k]) begin
                s += int'(d[8*k +: 8]);
                c++;
            end
        end
        if (c == 0) begin
            x.led = 0;
            x.fault = 1;
            x.alert = 1;
            x.at = e0 + 6;
        end else begin
            a = (2 * s + c) / (2 * c);
            if (a > 255) a = 255;
            out_r = (a < LO || a > HI) ? 1 : 0;
            x.led = a;
            x.fault = 0;
`ifdef TEMP_ALERT_HYST_EN
            if (out_r == 1) x.alert = 1;
            else if (a > LO && a < HI) x.alert = 0;
            else x.alert = model_alert;
`else
            x.alert = out_r;
`endif
            x.at = e0 + 22;
        end
        model_alert = x.alert;
        q.push_back(x);
    endtask

    exp_t m;
    always @(negedge clk) begin
        if (valid_o) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got pulse at cycle %0d, expected none", cyc);
            end else begin
                m = q.pop_front();
                check("led", int'(led_output_o), m.led);
                check("alert", int'(alert_o), m.alert);
                check("fault", int'(fault_o), m.fault);
                check("latency", cyc, m.at);
            end
        end
    end

    task automatic drain(input int limit);
        int t = 0;
        while (q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check("drain", q.size(), 0);
    endtask

    task automatic scan(input logic [39:0] d, input logic [4:0] e);
        int lim;
        @(negedge clk);
        data = d;
        en = e;
        start = 1'b1;
        push_exp(d, e, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        lim = (e == 5'd0) ? 3 : 19;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            data = 40'({$urandom(), $urandom()});
            en = 5'($urandom());
            start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        drain(60);
    endtask

    function automatic logic [39:0] all_of(input int v);
        logic [7:0] b;
        b = 8'(v);
        return {b, b, b, b, b};
    endfunction

    initial begin
        logic [39:0] d;
        logic [4:0]  e;
        int n;
        #1;
        check("rst_led", int'(led_output_o), 0);
        check("rst_alert", int'(alert_o), 0);
        check("rst_fault", int'(fault_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_valid", int'(valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        scan(all_of(22), 5'b11111);
        scan({8'd0, 8'd0, 8'd21, 8'd21, 8'd20}, 5'b00111);
        scan(all_of(50), 5'b00000);
        scan({24'd0, 8'd30, 8'd30}, 5'b00011);
        scan(all_of(26), 5'b11111);
        scan(all_of(19), 5'b11111);
        scan(all_of(18), 5'b10101);
        scan(all_of(27), 5'b01000);
        scan(all_of(255), 5'b11111);
        scan({8'd0, 8'd0, 8'd0, 8'd1, 8'd0}, 5'b00011);
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 5; k++) begin
                d[8*k +: 8] = (i < 14) ? 8'($urandom_range(14, 32))
                                       : 8'($urandom_range(0, 255));
            end
            e = 5'($urandom());
            scan(d, e);
        end
        scan(all_of(22), 5'b11111);

        @(negedge clk);
        data = all_of(40);
        en = 5'b11111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy_o), 0);
        check("abort_led", int'(led_output_o), 0);
        check("abort_alert", int'(alert_o), 0);
        check("abort_fault", int'(fault_o), 0);
        check("abort_valid", int'(valid_o), 0);
        model_alert = 0;
        repeat (3) @(negedge clk);
        d = {8'd24, 8'd23, 8'd22, 8'd21, 8'd20};
        e = 5'b11111;
        data = d;
        en = e;
        rst_n = 1'b1;
        n = cyc;
        push_exp(d, e, n + P + 1);
        push_exp(d, e, n + P + 1 + P + 23);
        drain(2 * (P + 23) + 40);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
